rf_wb_sched: RTL and testbench

Write-port scheduler and load scoreboard for the 8 x 16-bit CPU register file, which has a single write port. The ALU writeback (source A) and the multi-cycle memory/MMIO load return (source B) share that port. Source B is protected against starvation. The block tracks outstanding load destinations so decode can stall on RAW hazards, and drives the register file's write, writeregsel and writedata inputs from a registered stage.

---
 rtl/rf_wb_sched.sv | 131 +++++++++++++
 tb/tb_rf_wb_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
// Write-port scheduler and load scoreboard for the single-write-port register file.
// ALU writeback (A) normally wins the port. A load return (B) that keeps being denied
// is forced through once it has waited STARVE_MAX cycles. A pend bit per register
// tracks each outstanding load destination, so decode can stall on RAW hazards.
module rf_wb_sched #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 3,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_stall,
    input  logic          b_valid,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_reg,
    input  logic [AW-1:0] chk1_reg,
    input  logic [AW-1:0] chk2_reg,
    output logic          hazard1,
    output logic          hazard2,
    output logic          busy,
    output logic          rf_write,
    output logic [AW-1:0] rf_writeregsel,
    output logic [DW-1:0] rf_writedata,
    output logic          err
);

    localparam int unsigned NReg      = 2 ** AW;
    localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);

    logic            force_b;
    logic            grant_a;
    logic            grant_b;
    logic            b_hs;

    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            rf_write_q, rf_write_d;
    logic [AW-1:0]   rf_writeregsel_q, rf_writeregsel_d;
    logic [DW-1:0]   rf_writedata_q, rf_writedata_d;
    logic [NReg-1:0] pend_q, pend_d;
    logic            err_q, err_d;

    // Port arbitration: A has priority unless B has been starved long enough.
    always_comb begin
        force_b = b_valid && (starve_cnt_q == StarveMax);
        grant_a = a_valid && !force_b;
        grant_b = b_valid && !grant_a;
        b_hs    = b_valid && grant_b;
    end

    assign a_stall        = a_valid && force_b;
    assign b_ready        = grant_b;
    assign busy           = |pend_q;
    assign rf_write       = rf_write_q;
    assign rf_writeregsel = rf_writeregsel_q;
    assign rf_writedata   = rf_writedata_q;
    assign err            = err_q;

    // A register is unreadable while its load is pending or while its write is still
    // in flight (the register file only captures it at the end of the rf_write cycle).
    always_comb begin
        hazard1 = pend_q[chk1_reg] || (rf_write_q && (rf_writeregsel_q == chk1_reg));
        hazard2 = pend_q[chk2_reg] || (rf_write_q && (rf_writeregsel_q == chk2_reg));
    end

    // Next-state: starvation counter, write stage, scoreboard and sticky error.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!b_valid || b_hs) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        rf_write_d       = grant_a || grant_b;
        rf_writeregsel_d = rf_writeregsel_q;
        rf_writedata_d   = rf_writedata_q;
        if (grant_a) begin
            rf_writeregsel_d = a_reg;
            rf_writedata_d   = a_data;
        end else if (grant_b) begin
            rf_writeregsel_d = b_reg;
            rf_writedata_d   = b_data;
        end

        // Set is applied after clear so a same-register set/clear leaves the bit at 1.
        pend_d = pend_q;
        if (b_hs) begin
            pend_d[b_reg] = 1'b0;
        end
        if (iss_valid) begin
            pend_d[iss_reg] = 1'b1;
        end

        err_d = err_q;
        if (iss_valid && pend_q[iss_reg] && !(b_hs && (b_reg == iss_reg))) begin
            err_d = 1'b1;
        end
        if (b_hs && !pend_q[b_reg]) begin
            err_d = 1'b1;
        end
        if (grant_a && pend_q[a_reg]) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset drops any registered write.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q     <= 4'd0;
            rf_write_q       <= 1'b0;
            rf_writeregsel_q <= '0;
            rf_writedata_q   <= '0;
            pend_q           <= '0;
            err_q            <= 1'b0;
        end else begin
            starve_cnt_q     <= starve_cnt_d;
            rf_write_q       <= rf_write_d;
            rf_writeregsel_q <= rf_writeregsel_d;
            rf_writedata_q   <= rf_writedata_d;
            pend_q           <= pend_d;
            err_q            <= err_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: table of per-cycle vectors plus hand-written multi-cycle
// sequences. Expected writes go into a queue when a grant is expected and are
// compared against rf_write/sel/data one cycle later.
module tb_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, iss_valid;
    logic [2:0]  a_reg, b_reg, iss_reg, chk1_reg, chk2_reg;
    logic [15:0] a_data, b_data;
    logic        a_stall, b_ready, hazard1, hazard2, busy, rf_write, err;
    logic [2:0]  rf_writeregsel;
    logic [15:0] rf_writedata;

    int n_chk = 0;
    int n_err = 0;

    logic [18:0] wq[$];
    logic [2:0]  last_sel;
    logic [15:0] last_data;

    typedef struct {
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        bv;
        logic [2:0]  br;
        logic [15:0] bd;
        logic        iv;
        logic [2:0]  ir;
        logic [2:0]  c1;
        logic [2:0]  c2;
        logic        stall;
        logic        bready;
        logic        h1;
        logic        h2;
        logic        busy;
        logic        err;
        logic [1:0]  wr;   // 0 none, 1 A write, 2 B write
    } vec_t;

    vec_t vecs[18];

    rf_wb_sched #(.DW(16), .AW(3), .STARVE_MAX(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_reg          (a_reg),
        .a_data         (a_data),
        .a_stall        (a_stall),
        .b_valid        (b_valid),
        .b_reg          (b_reg),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .iss_valid      (iss_valid),
        .iss_reg        (iss_reg),
        .chk1_reg       (chk1_reg),
        .chk2_reg       (chk2_reg),
        .hazard1        (hazard1),
        .hazard2        (hazard2),
        .busy           (busy),
        .rf_write       (rf_write),
        .rf_writeregsel (rf_writeregsel),
        .rf_writedata   (rf_writedata),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic av, input logic [2:0] ar, input logic [15:0] ad,
        input logic bv, input logic [2:0] br, input logic [15:0] bd,
        input logic iv, input logic [2:0] ir, input logic [2:0] c1, input logic [2:0] c2,
        input logic stall, input logic bready, input logic h1, input logic h2,
        input logic bsy, input logic er, input logic [1:0] wr);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.iv = iv; v.ir = ir; v.c1 = c1; v.c2 = c2;
        v.stall = stall; v.bready = bready; v.h1 = h1; v.h2 = h2;
        v.busy = bsy; v.err = er; v.wr = wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        iss_valid = 0; iss_reg = 0; chk1_reg = 0; chk2_reg = 0;
    endtask

    // Compare the registered write stage against the scoreboard queue.
    task automatic check_write();
        logic [18:0] e;
        if (wq.size() > 0) begin
            e = wq.pop_front();
            chk("rf_write", 32'(rf_write), 32'd1);
            chk("rf_writeregsel", 32'(rf_writeregsel), 32'(e[18:16]));
            chk("rf_writedata", 32'(rf_writedata), 32'(e[15:0]));
            last_sel  = e[18:16];
            last_data = e[15:0];
        end else begin
            chk("rf_write_idle", 32'(rf_write), 32'd0);
            chk("sel_hold", 32'(rf_writeregsel), 32'(last_sel));
            chk("data_hold", 32'(rf_writedata), 32'(last_data));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_write();
        idle();
        rst = 1;
        last_sel = 0;
        last_data = 0;
        @(negedge clk);
        check_write();
        rst = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1;
        idle();
        last_sel = 0;
        last_data = 0;

        //         av ar  ad         bv br bd         iv ir c1 c2 st br h1 h2 bs er wr
        vecs[0]  = mk(1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 4, 0, 0, 1, 0, 1, 0, 0);
        vecs[5]  = mk(1, 1, 16'h0101, 1, 5, 16'h5555, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 1);
        vecs[6]  = mk(1, 2, 16'h0202, 1, 5, 16'h5555, 0, 0, 5, 1, 0, 0, 1, 1, 1, 0, 1);
        vecs[7]  = mk(1, 4, 16'h0404, 1, 5, 16'h5555, 0, 0, 5, 0, 0, 0, 1, 0, 1, 0, 1);
        vecs[8]  = mk(1, 6, 16'h0606, 1, 5, 16'h5555, 0, 0, 5, 0, 1, 1, 1, 0, 1, 0, 2);
        vecs[9]  = mk(1, 6, 16'h0606, 0, 0, 16'h0000, 0, 0, 5, 6, 0, 0, 1, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 6, 0, 0, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 16'h0000, 1, 2, 16'h2222, 1, 2, 2, 7, 0, 1, 1, 0, 1, 0, 2);
        vecs[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 7, 0, 0, 1, 0, 1, 0, 0);
        vecs[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 7, 0, 0, 1, 0, 1, 0, 0);
        vecs[15] = mk(0, 0, 16'h0000, 1, 6, 16'h6666, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2);
        vecs[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 6, 2, 0, 0, 1, 1, 1, 1, 0);
        vecs[17] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 6, 2, 0, 0, 0, 1, 1, 1, 0);

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_rf_write", 32'(rf_write), 32'd0);
        chk("rst_sel", 32'(rf_writeregsel), 32'd0);
        chk("rst_data", 32'(rf_writedata), 32'd0);
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_err0", 32'(err), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        rst = 0;

        // Table-driven vectors.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check_write();
            a_valid = vecs[i].av; a_reg = vecs[i].ar; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_reg = vecs[i].br; b_data = vecs[i].bd;
            iss_valid = vecs[i].iv; iss_reg = vecs[i].ir;
            chk1_reg = vecs[i].c1; chk2_reg = vecs[i].c2;
            #1;
            chk($sformatf("v%0d_a_stall", i), 32'(a_stall), 32'(vecs[i].stall));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].bready));
            chk($sformatf("v%0d_hazard1", i), 32'(hazard1), 32'(vecs[i].h1));
            chk($sformatf("v%0d_hazard2", i), 32'(hazard2), 32'(vecs[i].h2));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            if (vecs[i].wr == 2'd1) wq.push_back({vecs[i].ar, vecs[i].ad});
            if (vecs[i].wr == 2'd2) wq.push_back({vecs[i].br, vecs[i].bd});
        end

        // Reset mid-operation: build up starvation and a pending load, then reset
        // in the same cycle as an A grant.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_write();
            a_valid = 1; a_reg = 1; a_data = 16'h0001;
            b_valid = 1; b_reg = 0; b_data = 16'h0bad;
            #1;
            chk("pre_b_ready", 32'(b_ready), 32'd0);
            wq.push_back({3'd1, 16'h0001});
        end
        @(negedge clk);
        check_write();
        a_valid = 1; a_reg = 7; a_data = 16'h7777;
        iss_valid = 1; iss_reg = 3;
        rst = 1;
        last_sel = 0;
        last_data = 0;
        @(negedge clk);
        check_write();
        rst = 0;
        iss_valid = 0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);

        // Contention after reset: starvation count must restart from 0.
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check_write();
            end
            a_valid = 1; a_reg = 1; a_data = 16'h0011;
            b_valid = 1; b_reg = 0; b_data = 16'h0bad;
            #1;
            chk($sformatf("cont%0d_b_ready", k), 32'(b_ready), 32'(k == 3));
            chk($sformatf("cont%0d_a_stall", k), 32'(a_stall), 32'(k == 3));
            if (k < 3) wq.push_back({3'd1, 16'h0011});
            else       wq.push_back({3'd0, 16'h0bad});
        end
        @(negedge clk);
        check_write();
        a_valid = 1; a_reg = 1; a_data = 16'h0022;
        b_valid = 1; b_reg = 1; b_data = 16'h0c0c;
        #1;
        chk("after_force_a_stall", 32'(a_stall), 32'd0);
        chk("after_force_b_ready", 32'(b_ready), 32'd0);
        wq.push_back({3'd1, 16'h0022});

        // Double issue to the same register.
        do_reset();
        @(negedge clk);
        check_write();
        iss_valid = 1; iss_reg = 1;
        @(negedge clk);
        check_write();
        chk("first_issue_err", 32'(err), 32'd0);
        iss_valid = 1; iss_reg = 1;
        @(negedge clk);
        check_write();
        iss_valid = 0;
        chk("double_issue_err", 32'(err), 32'd1);

        // A write to a pending register (WAW) flags err but still writes.
        do_reset();
        @(negedge clk);
        check_write();
        iss_valid = 1; iss_reg = 4;
        @(negedge clk);
        check_write();
        iss_valid = 0;
        a_valid = 1; a_reg = 4; a_data = 16'h4444;
        #1;
        chk("waw_a_stall", 32'(a_stall), 32'd0);
        wq.push_back({3'd4, 16'h4444});
        @(negedge clk);
        check_write();
        a_valid = 0;
        chk("waw_err", 32'(err), 32'd1);
        chk("waw_busy", 32'(busy), 32'd1);

        @(negedge clk);
        check_write();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
